serial_divisibility_by_n_fsm: RTL



---
 rtl/serial_divisibility_by_n_fsm_if.sv | 34 +++
 rtl/serial_divisibility_by_n_fsm.sv | 111 +++++++++++
 2 files changed

// File: rtl/serial_divisibility_by_n_fsm_if.sv
// Bit-stream and result bundle for serial_divisibility_by_n_fsm.
// The lsb_first control exists only when SERIAL_DIV_LSB_FIRST_EN is defined.
interface serial_divisibility_by_n_fsm_if #(
    parameter int DIVISOR = 3,
    parameter int CNT_W   = 8
);
    localparam int RW = $clog2(DIVISOR);

    logic             start;
    logic             bit_valid;
    logic             new_bit;
`ifdef SERIAL_DIV_LSB_FIRST_EN
    logic             lsb_first;
`endif
    logic             div_by_n;
    logic [RW-1:0]    remainder;
    logic [CNT_W-1:0] bit_count;

    modport master (
`ifdef SERIAL_DIV_LSB_FIRST_EN
        output lsb_first,
`endif
        output start, bit_valid, new_bit,
        input  div_by_n, remainder, bit_count
    );

    modport slave (
`ifdef SERIAL_DIV_LSB_FIRST_EN
        input  lsb_first,
`endif
        input  start, bit_valid, new_bit,
        output div_by_n, remainder, bit_count
    );
endinterface

// File: rtl/serial_divisibility_by_n_fsm.sv
// Serial mod-DIVISOR tracker with saturating bit count; LSB-first mode under SERIAL_DIV_LSB_FIRST_EN.
// Latency: 1 cycle, outputs straight from registers.
// Backpressure: none, every qualified bit is accepted.
module serial_divisibility_by_n_fsm #(
    parameter int DIVISOR = 3,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    serial_divisibility_by_n_fsm_if.slave dv
);
    localparam int            RW    = $clog2(DIVISOR);
    localparam logic [RW:0]   N_EXT = DIVISOR[RW:0];

    generate
        if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
            $error("serial_divisibility_by_n_fsm: DIVISOR must be in 2..255");
        end
    endgenerate

    logic [RW-1:0]    rem, rem_d, rem_msb;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic [RW:0]      t, t_sub;

    // 2*rem + bit is below 2N, so one conditional subtract reduces it
    assign t       = {rem, dv.new_bit};
    assign t_sub   = t - N_EXT;
    assign rem_msb = (t >= N_EXT) ? t_sub[RW-1:0] : t[RW-1:0];
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef SERIAL_DIV_LSB_FIRST_EN
    localparam logic [RW-1:0] W_ONE = RW'(1);
    localparam logic [RW-1:0] W_TWO = (DIVISOR == 2) ? '0 : RW'(2);

    logic [RW-1:0] weight, weight_d, weight_lsb, rem_lsb;
    logic          mode_lsb, mode_d;
    logic [RW:0]   s, s_sub, u, u_sub;

    // weight tracks 2^k mod N for the next bit position
    assign s          = {1'b0, rem} + (dv.new_bit ? {1'b0, weight} : '0);
    assign s_sub      = s - N_EXT;
    assign rem_lsb    = (s >= N_EXT) ? s_sub[RW-1:0] : s[RW-1:0];
    assign u          = {weight, 1'b0};
    assign u_sub      = u - N_EXT;
    assign weight_lsb = (u >= N_EXT) ? u_sub[RW-1:0] : u[RW-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            cnt      <= '0;
`ifdef SERIAL_DIV_LSB_FIRST_EN
            weight   <= W_ONE;
            mode_lsb <= 1'b0;
`endif
        end else begin
            rem      <= rem_d;
            cnt      <= cnt_d;
`ifdef SERIAL_DIV_LSB_FIRST_EN
            weight   <= weight_d;
            mode_lsb <= mode_d;
`endif
        end
    end

    always_comb begin
        rem_d    = rem;
        cnt_d    = cnt;
`ifdef SERIAL_DIV_LSB_FIRST_EN
        weight_d = weight;
        mode_d   = mode_lsb;
`endif
        if (dv.start) begin
`ifdef SERIAL_DIV_LSB_FIRST_EN
            mode_d = dv.lsb_first;
`endif
            if (dv.bit_valid) begin
                // the sampled bit is the first bit of the new number
                rem_d    = RW'(dv.new_bit);
                cnt_d    = CNT_W'(1);
`ifdef SERIAL_DIV_LSB_FIRST_EN
                weight_d = W_TWO;
`endif
            end else begin
                rem_d    = '0;
                cnt_d    = '0;
`ifdef SERIAL_DIV_LSB_FIRST_EN
                weight_d = W_ONE;
`endif
            end
        end else if (dv.bit_valid) begin
            cnt_d = cnt_inc;
`ifdef SERIAL_DIV_LSB_FIRST_EN
            if (mode_lsb) begin
                rem_d    = rem_lsb;
                weight_d = weight_lsb;
            end else begin
                rem_d    = rem_msb;
            end
`else
            rem_d = rem_msb;
`endif
        end
    end

    always_comb begin
        dv.remainder = rem;
        dv.div_by_n  = (rem == '0);
        dv.bit_count = cnt;
    end
endmodule
